// File: rtl/l2_ic_refill_resp.sv
// Instruction-cache refill responder: fetches four memory words into a 128-bit line and hands it to L1.
// The last filled line is kept in a one-entry buffer so a repeated request to the same block skips memory.
module l2_ic_refill_resp #(
  parameter bit REUSE_EN = 1'b1,
  parameter int WORD_NUM = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         irq,
  input  logic         ic_rw_en,
  input  logic [27:0]  l2_addr,
  input  logic         l2_cache_rw,
  input  logic         complete,
  input  logic         inv,
  output logic         l2_busy,
  output logic         l2_rdy,
  output logic         mem_wr_ic_en,
  output logic [127:0] data_wd_l2,
  output logic         mem_rd_req,
  output logic [29:0]  mem_addr,
  input  logic [31:0]  mem_rd_data,
  input  logic         mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WRITE_L1 = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [27:0]    addr_q, tag_q;
  logic [1:0]     cnt_q;
  logic [127:0]   line_q;
  logic           valid_q, rdy_q;
  logic           rd_req, wr_req, hit, last_ack;

  // The l2_rdy cycle blocks acceptance so a level irq cannot fire twice.
  assign rd_req   = irq & ic_rw_en & ~l2_cache_rw & ~rdy_q;
  assign wr_req   = irq & ic_rw_en &  l2_cache_rw & ~rdy_q;
  assign hit      = REUSE_EN & valid_q & (l2_addr == tag_q);
  assign last_ack = mem_ack & (cnt_q == 2'(WORD_NUM - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rd_req)   state_d = hit ? WRITE_L1 : FETCH;
      FETCH:    if (last_ack) state_d = WRITE_L1;
      WRITE_L1: if (complete) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= ((state_q == WRITE_L1) & complete) | ((state_q == IDLE) & wr_req);
      if ((state_q == IDLE) && rd_req) begin
        addr_q <= l2_addr;
        cnt_q  <= '0;
      end
      if ((state_q == FETCH) && mem_ack) begin
        line_q[{cnt_q, 5'd0} +: 32] <= mem_rd_data;
        cnt_q                       <= cnt_q + 2'd1;
        if (last_ack) tag_q <= addr_q;
      end
      // A miss refills the buffer in place, so the old tag must not outlive its start.
      if (inv)                                        valid_q <= 1'b0;
      else if ((state_q == FETCH) && last_ack)        valid_q <= 1'b1;
      else if ((state_q == IDLE) && rd_req && !hit)   valid_q <= 1'b0;
    end
  end

  always_comb begin
    l2_busy      = (state_q != IDLE);
    l2_rdy       = rdy_q;
    mem_rd_req   = (state_q == FETCH);
    mem_addr     = '0;
    mem_wr_ic_en = 1'b0;
    data_wd_l2   = '0;
    case (state_q)
      FETCH:    mem_addr = {addr_q, cnt_q};
      WRITE_L1: begin
        mem_wr_ic_en = 1'b1;
        data_wd_l2   = line_q;
      end
      default: ;
    endcase
  end

endmodule
